// File: rtl/posit_encoder_param.sv
// rtl/posit_encoder_param.sv - multi-cycle posit encoder (regime/exponent/fraction -> posit)
//
// Serially assembles a posit from its decoded fields, one stream bit per clock,
// then rounds (nearest, ties-to-even), saturates and applies the sign.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   start        encode request, honoured only while idle
//   sign_in      sign of the value (1 = negative)
//   k_in         signed regime value (two's complement, KW bits)
//   exp_in       exponent field (max(ES,1) bits, ignored when ES=0)
//   mantissa_in  fraction bits MSB first, hidden one excluded
//   zero_in      value is exact zero
//   nar_in       value is NaR, takes priority over zero_in
//   posit_out    encoded posit, registered, held until the next result
//   busy         high while an encode is in flight
//   done         one-cycle pulse, posit_out valid from this cycle
module posit_encoder_param #(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int MW = 32,
    parameter int KW = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          sign_in,
    input  logic [KW-1:0]                 k_in,
    input  logic [((ES > 0) ? ES : 1)-1:0] exp_in,
    input  logic [MW-1:0]                 mantissa_in,
    input  logic                          zero_in,
    input  logic                          nar_in,
    output logic [N-1:0]                  posit_out,
    output logic                          busy,
    output logic                          done
);

    localparam int EW = (ES > 0) ? ES : 1;
    localparam int CW = $clog2(N);
    localparam int RW = KW + 1;

    localparam logic signed [31:0] K_SAT_MAX = N - 2;
    localparam logic signed [31:0] K_SAT_MIN = -(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        BUILD,
        ROUND,
        NEGATE,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic          sign_r, zero_r, nar_r;
    logic          k_neg, sat_max, sat_min;
    logic [RW-1:0] reg_left;     // regime bits still to emit, terminator included
    logic [EW-1:0] exp_sr;
    logic [2:0]    exp_left;
    logic [MW-1:0] mant_sr;
    logic [N-2:0]  body;
    logic          guard;
    logic [CW-1:0] cnt;

    // Regime length: k+1 run bits plus terminator for k>=0, -k run bits plus
    // terminator for k<0. RW is one bit wider than k so |k|+2 always fits.
    logic signed [31:0] k_wide;
    logic [RW-1:0]      k_ext;
    logic [RW-1:0]      reg_len;

    assign k_wide  = {{(32-KW){k_in[KW-1]}}, k_in};
    assign k_ext   = {k_in[KW-1], k_in};
    assign reg_len = k_in[KW-1] ? (RW'(1) - k_ext) : (k_ext + RW'(2));

    // Next stream bit: regime run, regime terminator, exponent, then mantissa.
    // The shift registers fill with zeros, so the trailing zeros come for free.
    logic stream_bit;
    always_comb begin
        stream_bit = 1'b0;
        if (reg_left > RW'(1))
            stream_bit = ~k_neg;
        else if (reg_left == RW'(1))
            stream_bit = k_neg;
        else if (exp_left != 3'd0)
            stream_bit = exp_sr[EW-1];
        else
            stream_bit = mant_sr[MW-1];
    end

    // Sticky covers whatever the N consumed bits did not reach. A pending
    // regime run is nonzero unless all that remains is a k>=0 zero terminator.
    logic sticky;
    assign sticky = (reg_left > RW'(1)) | ((reg_left == RW'(1)) & k_neg)
                  | (|exp_sr) | (|mant_sr);

    logic         round_up;
    logic [N-1:0] body_inc;
    logic [N-2:0] body_rnd;

    assign round_up = guard & (body[0] | sticky);
    assign body_inc = {1'b0, body} + N'(1);

    always_comb begin
        body_rnd = body;
        if (sat_max)
            body_rnd = '1;
        else if (sat_min)
            body_rnd = {{(N-2){1'b0}}, 1'b1};
        else if (round_up)
            body_rnd = body_inc[N-1] ? '1 : body_inc[N-2:0];
        // A nonzero value never rounds to zero; it clamps to minpos instead.
        if (body_rnd == '0)
            body_rnd = {{(N-2){1'b0}}, 1'b1};
    end

    logic [N-1:0] mag;
    logic [N-1:0] posit_nxt;

    assign mag = {1'b0, body};

    always_comb begin
        posit_nxt = mag;
        if (nar_r)
            posit_nxt = {1'b1, {(N-1){1'b0}}};
        else if (zero_r)
            posit_nxt = '0;
        else if (sign_r)
            posit_nxt = ~mag + N'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUILD;
            BUILD:   if (cnt == '0) state_nxt = ROUND;
            ROUND:   state_nxt = NEGATE;
            NEGATE:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_r    <= 1'b0;
            zero_r    <= 1'b0;
            nar_r     <= 1'b0;
            k_neg     <= 1'b0;
            sat_max   <= 1'b0;
            sat_min   <= 1'b0;
            reg_left  <= '0;
            exp_sr    <= '0;
            exp_left  <= 3'd0;
            mant_sr   <= '0;
            body      <= '0;
            guard     <= 1'b0;
            cnt       <= '0;
            posit_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_r   <= sign_in;
                        zero_r   <= zero_in;
                        nar_r    <= nar_in;
                        k_neg    <= k_in[KW-1];
                        sat_max  <= (k_wide >= K_SAT_MAX);
                        sat_min  <= (k_wide <= K_SAT_MIN);
                        reg_left <= reg_len;
                        exp_sr   <= (ES > 0) ? exp_in : '0;
                        exp_left <= 3'(ES);
                        mant_sr  <= mantissa_in;
                        body     <= '0;
                        guard    <= 1'b0;
                        cnt      <= CW'(N - 1);
                    end
                end
                BUILD: begin
                    // First N-1 bits shift into the body MSB first; the last is guard.
                    if (cnt != '0) begin
                        body <= {body[N-3:0], stream_bit};
                        cnt  <= cnt - CW'(1);
                    end else begin
                        guard <= stream_bit;
                    end
                    if (reg_left != '0) begin
                        reg_left <= reg_left - RW'(1);
                    end else if (exp_left != 3'd0) begin
                        exp_sr   <= exp_sr << 1;
                        exp_left <= exp_left - 3'd1;
                    end else begin
                        mant_sr <= mant_sr << 1;
                    end
                end
                ROUND: begin
                    body <= body_rnd;
                end
                NEGATE: begin
                    posit_out <= posit_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_encoder_param.sv
// tb/tb_posit_encoder_param.sv - self-checking bench for posit_encoder_param
module tb_posit_encoder_param;

    localparam int N  = 32;
    localparam int ES = 2;
    localparam int MW = 32;
    localparam int KW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          sign_in = 1'b0;
    logic [KW-1:0] k_in = '0;
    logic [1:0]    exp_in = '0;
    logic [MW-1:0] mantissa_in = '0;
    logic          zero_in = 1'b0;
    logic          nar_in = 1'b0;
    logic [N-1:0]  posit_out;
    logic          busy;
    logic          done;

    posit_encoder_param #(.N(N), .ES(ES), .MW(MW), .KW(KW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sign_in     (sign_in),
        .k_in        (k_in),
        .exp_in      (exp_in),
        .mantissa_in (mantissa_in),
        .zero_in     (zero_in),
        .nar_in      (nar_in),
        .posit_out   (posit_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        int          k;
        logic [1:0]  ex;
        logic [31:0] mant;
        logic        zero;
        logic        nar;
        logic [31:0] want;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb_q[$];
    logic [31:0] mon_want;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, want);
        end
    endtask

    task automatic add(input logic s, input int k, input logic [1:0] ex, input logic [31:0] mant,
                       input logic z, input logic nr, input logic [31:0] want);
        vec_t v;
        v.sign = s; v.k = k; v.ex = ex; v.mant = mant;
        v.zero = z; v.nar = nr; v.want = want;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        sign_in     = v.sign;
        k_in        = v.k[KW-1:0];
        exp_in      = v.ex;
        mantissa_in = v.mant;
        zero_in     = v.zero;
        nar_in      = v.nar;
    endtask

    // Scoreboard: every done pops the oldest expected result.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 posit_out=%h, required no done", posit_out);
            end else begin
                mon_want = sb_q.pop_front();
                check("result", posit_out, mon_want);
            end
        end
    end

    task automatic encode(input vec_t v, input bit glitch);
        int cyc;
        bit seen;
        @(negedge clk);
        drive(v);
        start = 1'b1;
        sb_q.push_back(v.want);
        @(posedge clk);
        #1 start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_after_accept", busy, 1);
            if (glitch && cyc == 5) begin
                start   = 1'b1;
                sign_in = ~sign_in;
                k_in    = 7'd5;
            end
            if (glitch && cyc == 6) start = 1'b0;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
            check("latency", cyc, N + 3);
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_idle", busy, 0);
    endtask

    vec_t va, vb;
    int   cyc1, cyc2;
    bit   any_done;

    initial begin
        add(0,   0, 0, 32'h00000000, 0, 0, 32'h40000000);
        add(1,   0, 0, 32'h00000000, 0, 0, 32'hC0000000);
        add(0,  -1, 3, 32'h80000000, 0, 0, 32'h3C000000);
        add(0,   0, 0, 32'hFFFFFFFF, 0, 0, 32'h48000000);
        add(0,   0, 0, 32'h00000010, 0, 0, 32'h40000000);
        add(0,  40, 0, 32'h00000000, 0, 0, 32'h7FFFFFFF);
        add(0, -40, 0, 32'h00000000, 0, 0, 32'h00000001);
        add(1, -40, 0, 32'h00000000, 0, 0, 32'hFFFFFFFF);
        add(1,   0, 2, 32'h12345678, 1, 0, 32'h00000000);
        add(1,   5, 1, 32'h00000000, 1, 1, 32'h80000000);
        add(0,   1, 2, 32'h40000000, 0, 0, 32'h69000000);
        add(1,   1, 2, 32'h40000000, 0, 0, 32'h97000000);
        add(0,  -3, 1, 32'h00000000, 0, 0, 32'h0A000000);
        add(0,  29, 0, 32'h00000000, 0, 0, 32'h7FFFFFFE);
        add(0,  29, 2, 32'h00000000, 0, 0, 32'h7FFFFFFE);
        add(0,  29, 3, 32'h00000000, 0, 0, 32'h7FFFFFFF);
        add(0,  30, 0, 32'h00000000, 0, 0, 32'h7FFFFFFF);
        add(0, -30, 0, 32'h00000000, 0, 0, 32'h00000001);
        add(0, -31, 0, 32'h00000000, 0, 0, 32'h00000001);
        add(0, -29, 0, 32'h00000000, 0, 0, 32'h00000002);
        add(0, -29, 3, 32'h00000000, 0, 0, 32'h00000004);
        add(0,   0, 3, 32'hFFFFFFFF, 0, 0, 32'h60000000);
        add(0, -64, 3, 32'hFFFFFFFF, 0, 0, 32'h00000001);
        add(0,  63, 0, 32'h00000000, 0, 0, 32'h7FFFFFFF);

        #2 rst = 1'b0;
        #10;
        check("reset_posit", posit_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            encode(tbl[i], i == 10);

        // Back-to-back: start held high through DONE is taken in the next IDLE.
        va = tbl[0];
        vb = tbl[2];
        @(negedge clk);
        drive(va);
        start = 1'b1;
        sb_q.push_back(va.want);
        @(posedge clk);
        #1 drive(vb);
        sb_q.push_back(vb.want);
        cyc1 = 0;
        while (!done && cyc1 < 200) begin
            @(negedge clk);
            cyc1++;
        end
        check("b2b_first_latency", cyc1, N + 3);
        cyc2 = 0;
        do begin
            @(negedge clk);
            cyc2++;
        end while (!done && cyc2 < 200);
        start = 1'b0;
        check("b2b_period", cyc2, N + 4);
        @(negedge clk);
        check("b2b_done_one_cycle", done, 0);

        // Asynchronous reset in the middle of BUILD.
        @(negedge clk);
        drive(tbl[3]);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_posit", posit_out, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        any_done = 1'b0;
        repeat (N + 8) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        check("no_done_after_reset", any_done, 0);
        encode(tbl[11], 1'b0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
